// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out transmitter. A WIDTH-bit word is captured when
// load && ready on a rising edge and shifted out LSB-first on s_out, one bit
// every DIV clock cycles. The LSB-first order matches the team's SIPO
// receivers, which insert at the MSB and shift toward bit 0.
//
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR of the captured word) after the data bits.
//
// Parameters
//   WIDTH     data word width in bits (>= 2)
//   DIV       clock cycles per serial bit (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   p_in       parallel word, sampled only when a load is accepted
//   load       load request, accepted when load && ready at an edge
//   ready      idle, a word can be accepted
//   s_out      serial data (LSB first), 0 while idle
//   s_valid    s_out carries a data or parity bit
//   done       one-cycle pulse in the first idle cycle after a frame
//   state_dbg  current FSM state (0 idle, 1 shift, 2 parity)
//
// Handshake: a word transfers on a rising edge where load && ready are both
// 1. While ready is 0 the load input is ignored: nothing is queued and p_in
// is not sampled. done and ready rise together, so a load held high in the
// done cycle starts the next frame after a one-cycle gap.
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] p_in,
    input  logic             load,
    output logic             ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [BW-1:0]    bit_cnt, bit_cnt_nx;
    logic [DW-1:0]    div_cnt, div_cnt_nx;
    logic             done_q, done_nx;
    logic             div_last;
    logic             bit_last;

`ifdef PISO_PARITY_EN
    logic             par_q, par_nx;
`endif

    assign div_last = (div_cnt == DW'(DIV - 1));
    assign bit_last = (bit_cnt == BW'(WIDTH - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            div_cnt <= div_cnt_nx;
            done_q  <= done_nx;
`ifdef PISO_PARITY_EN
            par_q   <= par_nx;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        div_cnt_nx = div_cnt;
        done_nx    = 1'b0;
`ifdef PISO_PARITY_EN
        par_nx     = par_q;
`endif
        case (state)
            IDLE: begin
                if (load) begin
                    shreg_nx   = p_in;
                    bit_cnt_nx = '0;
                    div_cnt_nx = '0;
`ifdef PISO_PARITY_EN
                    par_nx     = ^p_in;
`endif
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_cnt_nx = '0;
                    shreg_nx   = shreg >> 1;
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_last) begin
                        // Counters are returned to 0 so idle always looks
                        // the same as just after reset.
                        bit_cnt_nx = '0;
`ifdef PISO_PARITY_EN
                        state_nx   = PARITY;
`else
                        state_nx   = IDLE;
                        done_nx    = 1'b1;
`endif
                    end
                end else begin
                    div_cnt_nx = div_cnt + 1'b1;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (div_last) begin
                    div_cnt_nx = '0;
                    state_nx   = IDLE;
                    done_nx    = 1'b1;
                end else begin
                    div_cnt_nx = div_cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs depend only on registers; no path from load or p_in.
    always_comb begin
        s_out = 1'b0;
        case (state)
            SHIFT:   s_out = shreg[0];
`ifdef PISO_PARITY_EN
            PARITY:  s_out = par_q;
`endif
            default: s_out = 1'b0;
        endcase
    end

    assign ready     = (state == IDLE);
    assign s_valid   = (state != IDLE);
    assign done      = done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//
// Two instances share clock and reset: WIDTH=4/DIV=4 and WIDTH=4/DIV=1.
// Inputs are driven and outputs sampled on the falling edge. The reference
// model expands a word into the expected per-cycle output tuple
// {s_valid, s_out, ready, done} from the frame timing rules.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] p4 = '0, p1 = '0;
    logic         load4 = 1'b0, load1 = 1'b0;
    logic         ready4, s_out4, s_valid4, done4;
    logic         ready1, s_out1, s_valid1, done1;
    logic [1:0]   st4, st1;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic [W-1:0] p_in;
        logic [3:0]   exp_seq;   // transmission order, first bit at MSB
        logic         exp_par;
    } vec_t;
    vec_t tbl[5];

    piso_serializer #(.WIDTH(W), .DIV(4)) dut4 (
        .clk(clk), .reset(reset), .p_in(p4), .load(load4),
        .ready(ready4), .s_out(s_out4), .s_valid(s_valid4), .done(done4),
        .state_dbg(st4)
    );

    piso_serializer #(.WIDTH(W), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .p_in(p1), .load(load1),
        .ready(ready1), .s_out(s_out1), .s_valid(s_valid1), .done(done1),
        .state_dbg(st1)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] outs(input int sel);
        if (sel == 4) return {s_valid4, s_out4, ready4, done4};
        return {s_valid1, s_out1, ready1, done1};
    endfunction

    task automatic drive(input int sel, input logic l, input logic [W-1:0] p);
        if (sel == 4) begin
            load4 = l;
            p4    = p;
        end else begin
            load1 = l;
            p1    = p;
        end
    endtask

    // Reference model: one tuple per cycle after the accepting edge.
    task automatic build_frame(input logic [W-1:0] w, input int d);
        logic par;
        for (int k = 0; k < W; k++)
            for (int c = 0; c < d; c++)
                exp_q.push_back({1'b1, w[k], 1'b0, 1'b0});
`ifdef PISO_PARITY_EN
        par = ($countones(w) % 2) == 1;
        for (int c = 0; c < d; c++)
            exp_q.push_back({1'b1, par, 1'b0, 1'b0});
`else
        par = 1'b0;
`endif
        exp_q.push_back(4'b0011);
    endtask

    // Send one word; optionally pulse a junk load at cycle 'inject' of the frame.
    task automatic send(input int sel, input logic [W-1:0] w, input int inject,
                        output logic [4:0] seq);
        int         d;
        int         budget;
        int         idx;
        logic [3:0] o, e;
        logic [W-1:0] rx;
        d = (sel == 4) ? 4 : 1;
        budget = 0;
        rx = '0;
        seq = '0;
        o = outs(sel);
        while (o[1] !== 1'b1 && budget < 50) begin
            @(negedge clk);
            o = outs(sel);
            budget++;
        end
        check($sformatf("ready_wait sel%0d", sel), {31'd0, o[1]}, 32'd1);
        exp_q.delete();
        build_frame(w, d);
        drive(sel, 1'b1, w);
        @(negedge clk);
        drive(sel, 1'b0, w);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = outs(sel);
            check($sformatf("frame sel%0d w=%h cyc%0d {sv,so,rdy,done}", sel, w, idx), {28'd0, o}, {28'd0, e});
            // Mid-bit sampling, as a SIPO receiver clocked once per bit would do.
            if ((idx % d) == (d / 2) && idx < F * d) begin
                seq = {seq[3:0], o[2]};
                if (idx < W * d) rx = {o[2], rx[W-1:1]};
            end
            if (inject >= 0 && idx == inject) drive(sel, 1'b1, 4'hF);
            else if (inject >= 0 && idx == inject + 1) drive(sel, 1'b0, w);
            idx++;
            @(negedge clk);
        end
        drive(sel, 1'b0, w);
        check($sformatf("sipo_loopback sel%0d", sel), {28'd0, rx}, {28'd0, w});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [4:0] seq;
        logic [3:0] o, e;
        int idx;
        bit saw_done;

        tbl[0] = '{4'b1011, 4'b1101, 1'b1};
        tbl[1] = '{4'b0110, 4'b0110, 1'b0};
        tbl[2] = '{4'b0001, 4'b1000, 1'b1};
        tbl[3] = '{4'b1100, 4'b0011, 1'b0};
        tbl[4] = '{4'b1110, 4'b0111, 1'b1};

        // Reset, with load asserted: reset must win.
        reset = 1'b0;
        drive(4, 1'b1, 4'hA);
        drive(1, 1'b1, 4'h5);
        repeat (3) @(negedge clk);
        check("reset_state dut4", {28'd0, outs(4)}, 32'h2);
        check("reset_state dut1", {28'd0, outs(1)}, 32'h2);
        drive(4, 1'b0, 4'h0);
        drive(1, 1'b0, 4'h0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven frames on DIV=4
        for (int i = 0; i < 5; i++) begin
            send(4, tbl[i].p_in, -1, seq);
`ifdef PISO_PARITY_EN
            check($sformatf("tbl%0d serial_seq", i), {28'd0, seq[4:1]}, {28'd0, tbl[i].exp_seq});
            check($sformatf("tbl%0d parity", i), {31'd0, seq[0]}, {31'd0, tbl[i].exp_par});
`else
            check($sformatf("tbl%0d serial_seq", i), {28'd0, seq[3:0]}, {28'd0, tbl[i].exp_seq});
`endif
        end

        // Load held high on DIV=1: back-to-back frames, p_in sampled only on accept.
        exp_q.delete();
        build_frame(4'b0110, 1);
        build_frame(4'b0101, 1);
        drive(1, 1'b1, 4'b0110);
        @(negedge clk);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = outs(1);
            check($sformatf("b2b cyc%0d {sv,so,rdy,done}", idx), {28'd0, o}, {28'd0, e});
            if (idx == 1) drive(1, 1'b1, 4'b1111);
            else if (idx == F) drive(1, 1'b1, 4'b0101);
            else if (idx == F + 1) drive(1, 1'b0, 4'b0000);
            idx++;
            @(negedge clk);
        end

        // Ignored load during SHIFT on both instances
        send(4, 4'b0010, 5, seq);
        send(1, 4'b1001, 1, seq);

        // Reset mid-frame: load at edge 0, reset sampled at edge 7.
        drive(4, 1'b1, 4'b1011);
        @(negedge clk);
        drive(4, 1'b0, 4'b1011);
        repeat (6) @(negedge clk);
        check("pre_abort {sv,so,rdy,done}", {28'd0, outs(4)}, 32'hC);
        reset = 1'b0;
        @(negedge clk);
        check("abort {sv,so,rdy,done}", {28'd0, outs(4)}, 32'h2);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done4) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        send(4, 4'b1011, -1, seq);

        // Loopback over every 4-bit value
        for (int v = 0; v < 16; v++) send(4, 4'(v), -1, seq);

        // Randomized frames with idle gaps and junk loads
        for (int i = 0; i < 40; i++) begin
            int sel, d, gap, inj;
            sel = ($urandom_range(0, 1) == 1) ? 4 : 1;
            d   = (sel == 4) ? 4 : 1;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                check($sformatf("rand%0d idle sel%0d", i, sel), {28'd0, outs(sel)}, 32'h2);
                @(negedge clk);
            end
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, F * d - 2) : -1;
            send(sel, 4'($urandom_range(0, 15)), inj, seq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parameterised parallel-in/serial-out transmitter: captures a WIDTH-bit word on a load handshake and shifts it out LSB-first on a single serial line, one bit per DIV clock cycles. This block is the sending end for the team's SIPO receive shift registers. Those registers insert at the MSB and shift toward bit 0, so an LSB-first stream lands correctly aligned after WIDTH receive shifts. It provides ready/done status for a controlling FSM, an internal bit-rate divider, and optional parity.

## Interface

**Parameters**
- `WIDTH`, default 4: data word width in bits; must be ≥ 2.
- `DIV`, default 1: clock cycles per serial bit; must be ≥ 1.

**Ports**
- `clk`, in, 1: single system clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `p_in`, in, WIDTH: parallel word; sampled only when a load is accepted.
- `load`, in, 1: load request; accepted on an edge where `load && ready`.
- `ready`, out, 1: block is idle and can accept a word.
- `s_out`, out, 1: serial data, LSB first.
- `s_valid`, out, 1: `s_out` carries a data or parity bit.
- `done`, out, 1: one-cycle pulse when a frame completes.

## Operation

**Reset** (`reset`=0 at an edge): state IDLE, `ready`=1, `s_out`=0, `s_valid`=0, `done`=0, all counters 0.
- Reset overrides load.
- Reset mid-frame aborts the frame with no `done` pulse.

**States**
- IDLE
  - Outputs: `ready`=1, `s_valid`=0, `s_out`=0.
  - On `load`=1: capture `p_in` into the shift register, clear the bit counter and divider counter, go to SHIFT.
- SHIFT
  - Outputs: `ready`=0, `s_valid`=1, `s_out` = shift register bit 0.
  - The divider counts 0..DIV-1; on terminal count the register shifts right by one and the bit counter increments.
  - After bit WIDTH-1 completes: go to PARITY if compiled in, else go to IDLE with `done`=1.
- PARITY (macro only)
  - Outputs: `s_valid`=1, `s_out` = parity bit.
  - Holds for DIV cycles, then goes to IDLE with `done`=1.

**Handshake and counter rules**
- `load` while `ready`=0 is ignored. It is not queued, and `p_in` is not sampled.
- `done` is asserted in the first IDLE cycle after a frame, together with `ready`=1. A `load` in that same cycle is accepted, giving back-to-back frames with a one-cycle gap.
- Bit counter width is $clog2(WIDTH+1); divider width is max(1, $clog2(DIV)).
- Both counters reset to 0 on every accepted load; no wrap-around occurs within a frame.

## Timing

Let edge N be the edge that accepts the load.
- Data bit k (0..WIDTH-1) is on `s_out` with `s_valid`=1 from edge N+k·DIV until edge N+(k+1)·DIV.
- Parity bit, if enabled, occupies edges N+WIDTH·DIV through N+(WIDTH+1)·DIV.
- Let F = WIDTH, or WIDTH+1 with parity. At edge N+F·DIV:
  - `s_valid`→0, `s_out`→0, `ready`→1, `done`→1;
  - `done` returns to 0 at the next edge.
- Load-to-first-bit latency: 0 cycles after the accepting edge (bit 0 appears with `ready` falling).
- Minimum frame period: F·DIV+1 cycles.
- All outputs are registered; no combinational path from `load` or `p_in` to any output.

## Configuration

- `PISO_PARITY_EN` defined:
  - PARITY state is compiled in; one extra bit period follows the data.
  - Parity bit = XOR of the captured word, i.e. even parity over data+parity.
- `PISO_PARITY_EN` not defined:
  - No PARITY state; frame is exactly WIDTH bits.
  - `done` follows the last data bit.

## Test plan

- WIDTH=4, DIV=4, no parity, load `p_in`=4'b1011 at edge 0 → `s_out` = 1,1,0,1, each held 4 cycles over edges 0–16; `done`=1 and `ready`=1 at edge 16 only.
- Same stimulus with `PISO_PARITY_EN` → after the 4 data bits, parity bit 1 for 4 cycles; `done` at edge 20.
- DIV=1, `p_in`=4'b0110, `load` held high continuously → `s_out` = 0,1,1,0, then gap cycle with `done`=1, then a new frame starts at edge 5; `p_in` is sampled only at edges 0 and 5.
- During SHIFT, pulse `load` with `p_in`=4'b1111 → ignored; serial stream and `done` timing unchanged from the first word.
- Assert `reset`=0 at edge 6 of a DIV=4 frame → at edge 7: `s_valid`=0, `s_out`=0, `ready`=1; no `done` pulse; next load transmits normally.
- Loopback into the 4-bit SIPO receiver clocked once per bit period → after 4 bit periods the receiver parallel output equals the loaded word, for all 16 values.
